led_count_ctrl: RTL and testbench

Run/pause/step controller for the LED up/down counter datapath. It sits between the board buttons and switches and the W-bit counter that drives `led`, and it sequences every count event. It synchronises and debounces the user inputs, divides the system clock into count ticks, and runs a four-state FSM. It issues registered `cnt_en`, `cnt_up` and `cnt_clr` commands, with an optional bounce mode that reverses direction at the counter limits.

---
 rtl/led_count_ctrl_pkg.sv | 35 +++
 rtl/led_count_ctrl_debounce.sv | 69 ++++++
 rtl/led_count_ctrl.sv | 166 ++++++++++++++++
 tb/tb_led_count_ctrl.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/led_count_ctrl_pkg.sv
// Shared types and defaults for the LED counter run/pause/step controller.
package led_ctrl_pkg;

    typedef enum logic [1:0] {
        CLEAR = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        STEP  = 2'd3
    } ctrl_state_t;

    localparam int TICK_DIV_DEF  = 50_000_000;
    localparam int DB_CYCLES_DEF = 1_000_000;

    // Bounce mode turns around at the limits so the datapath never wraps.
    function automatic logic next_dir(
        input logic dir,
        input logic bounce,
        input logic sw_dir,
        input logic at_max,
        input logic at_zero
    );
        logic nd;
        if (!bounce) begin
            nd = sw_dir;
        end else if (dir && at_max) begin
            nd = 1'b0;
        end else if (!dir && at_zero) begin
            nd = 1'b1;
        end else begin
            nd = dir;
        end
        return nd;
    endfunction

endpackage

// File: rtl/led_count_ctrl_debounce.sv
// Two-flop synchroniser, stability-count debouncer and registered rising-edge
// detector for one asynchronous board input.
module debounce
    import led_ctrl_pkg::*;
#(
    parameter int DB_CYCLES = DB_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic level,
    output logic press
);

    localparam int CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

    logic          sync1_r;
    logic          sync2_r;
    logic          level_r;
    logic          level_d_r;
    logic          press_r;
    logic [CW-1:0] cnt_r;

    // Synchronise the raw input into the clock domain
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
        end else begin
            sync1_r <= din;
            sync2_r <= sync1_r;
        end
    end

    // Accept a new level only after DB_CYCLES consecutive differing samples
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level_r <= 1'b0;
            cnt_r   <= {CW{1'b0}};
        end else if (sync2_r != level_r) begin
            if (cnt_r == CNT_LAST) begin
                level_r <= sync2_r;
                cnt_r   <= {CW{1'b0}};
            end else begin
                level_r <= level_r;
                cnt_r   <= cnt_r + CW'(1);
            end
        end else begin
            level_r <= level_r;
            cnt_r   <= {CW{1'b0}};
        end
    end

    // One-cycle press on the rising edge of the debounced level
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level_d_r <= 1'b0;
            press_r   <= 1'b0;
        end else begin
            level_d_r <= level_r;
            press_r   <= level_r & ~level_d_r;
        end
    end

    assign level = level_r;
    assign press = press_r;

endmodule

// File: rtl/led_count_ctrl.sv
// Run/pause/step controller: debounced user inputs, tick prescaler, control FSM
// and direction register issuing registered strobes to the LED counter.
module led_count_ctrl
    import led_ctrl_pkg::*;
#(
    parameter int W         = 4,
    parameter int TICK_DIV  = TICK_DIV_DEF,
    parameter int DB_CYCLES = DB_CYCLES_DEF
) (
    input  logic         clk,
    input  logic         rst_btn_n,
    input  logic         sw_dir,
    input  logic         sw_bounce,
    input  logic         btn_pause,
    input  logic         btn_step,
    input  logic         btn_clr,
    input  logic [W-1:0] cnt_val,
    output logic         cnt_en,
    output logic         cnt_up,
    output logic         cnt_clr,
    output logic [1:0]   state
);

    localparam int PW = $clog2(TICK_DIV);
    localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);
    localparam logic [W-1:0]  CNT_MAX  = {W{1'b1}};

    ctrl_state_t   state_r;
    ctrl_state_t   ret_r;
    logic [PW-1:0] presc_r;
    logic          dir_r;
    logic          cnt_en_r;
    logic          cnt_up_r;
    logic          cnt_clr_r;
    logic          bounce_sync1_r;
    logic          bounce_sync2_r;

    logic dir_level_s;
    logic dir_press_unused;
    logic pause_press_s;
    logic step_press_s;
    logic clr_press_s;
    logic pause_level_unused;
    logic step_level_unused;
    logic clr_level_unused;
    logic tick_s;
    logic dir_next_s;

    debounce #(.DB_CYCLES(DB_CYCLES)) u_db_dir (
        .clk(clk), .rst_n(rst_btn_n), .din(sw_dir),
        .level(dir_level_s), .press(dir_press_unused)
    );
    debounce #(.DB_CYCLES(DB_CYCLES)) u_db_pause (
        .clk(clk), .rst_n(rst_btn_n), .din(btn_pause),
        .level(pause_level_unused), .press(pause_press_s)
    );
    debounce #(.DB_CYCLES(DB_CYCLES)) u_db_step (
        .clk(clk), .rst_n(rst_btn_n), .din(btn_step),
        .level(step_level_unused), .press(step_press_s)
    );
    debounce #(.DB_CYCLES(DB_CYCLES)) u_db_clr (
        .clk(clk), .rst_n(rst_btn_n), .din(btn_clr),
        .level(clr_level_unused), .press(clr_press_s)
    );

    // Bounce switch is a static mode select, so it is synchronised only
    always_ff @(posedge clk or negedge rst_btn_n) begin
        if (!rst_btn_n) begin
            bounce_sync1_r <= 1'b0;
            bounce_sync2_r <= 1'b0;
        end else begin
            bounce_sync1_r <= sw_bounce;
            bounce_sync2_r <= bounce_sync1_r;
        end
    end

    // Tick detect and direction to use if a count event happens this cycle
    always_comb begin
        tick_s     = (presc_r == PRE_LAST);
        dir_next_s = next_dir(dir_r, bounce_sync2_r, dir_level_s,
                              (cnt_val == CNT_MAX), (cnt_val == {W{1'b0}}));
    end

    // Control FSM with prescaler, direction register and registered strobes
    always_ff @(posedge clk or negedge rst_btn_n) begin
        if (!rst_btn_n) begin
            state_r   <= CLEAR;
            ret_r     <= RUN;
            presc_r   <= {PW{1'b0}};
            dir_r     <= 1'b1;
            cnt_en_r  <= 1'b0;
            cnt_up_r  <= 1'b1;
            cnt_clr_r <= 1'b0;
        end else begin
            cnt_en_r  <= 1'b0;
            cnt_clr_r <= 1'b0;
            case (state_r)
                // After reset cnt_clr_r is low, so CLEAR first issues the strobe
                CLEAR: begin
                    presc_r <= {PW{1'b0}};
                    if (cnt_clr_r) begin
                        state_r <= ret_r;
                    end else begin
                        cnt_clr_r <= 1'b1;
                        state_r   <= CLEAR;
                    end
                end
                RUN: begin
                    if (clr_press_s) begin
                        ret_r     <= RUN;
                        state_r   <= CLEAR;
                        cnt_clr_r <= 1'b1;
                        presc_r   <= {PW{1'b0}};
                    end else if (pause_press_s) begin
                        state_r <= PAUSE;
                        presc_r <= {PW{1'b0}};
                    end else if (tick_s) begin
                        presc_r  <= {PW{1'b0}};
                        dir_r    <= dir_next_s;
                        cnt_up_r <= dir_next_s;
                        cnt_en_r <= 1'b1;
                    end else begin
                        presc_r <= presc_r + PW'(1);
                    end
                end
                PAUSE: begin
                    presc_r <= {PW{1'b0}};
                    if (clr_press_s) begin
                        ret_r     <= PAUSE;
                        state_r   <= CLEAR;
                        cnt_clr_r <= 1'b1;
                    end else if (pause_press_s) begin
                        state_r <= RUN;
                    end else if (step_press_s) begin
                        state_r <= STEP;
                    end else begin
                        state_r <= PAUSE;
                    end
                end
                STEP: begin
                    presc_r <= {PW{1'b0}};
                    if (clr_press_s) begin
                        ret_r     <= PAUSE;
                        state_r   <= CLEAR;
                        cnt_clr_r <= 1'b1;
                    end else begin
                        dir_r    <= dir_next_s;
                        cnt_up_r <= dir_next_s;
                        cnt_en_r <= 1'b1;
                        state_r  <= pause_press_s ? RUN : PAUSE;
                    end
                end
                default: begin
                    state_r <= CLEAR;
                    presc_r <= {PW{1'b0}};
                end
            endcase
        end
    end

    assign cnt_en  = cnt_en_r;
    assign cnt_up  = cnt_up_r;
    assign cnt_clr = cnt_clr_r;
    assign state   = state_r;

endmodule

// File: tb/tb_led_count_ctrl.sv
// Self-checking bench for led_count_ctrl with TICK_DIV=4, DB_CYCLES=3 and a
// behavioural 4-bit up/down counter standing in for the datapath.
module tb_led_count_ctrl;

    typedef struct packed {
        logic       up;
        logic [3:0] val;
    } sb_t;

    typedef struct {
        logic pause;
        logic step;
        logic clr;
        int   win;
        int   exp_state;
        int   exp_strobes;
        int   exp_step;
        int   exp_clrs;
        int   exp_val;
    } vec_t;

    localparam int NV = 10;

    logic       clk = 1'b0;
    logic       rst_btn_n = 1'b1;
    logic       sw_dir = 1'b1;
    logic       sw_bounce = 1'b0;
    logic       btn_pause = 1'b0;
    logic       btn_step = 1'b0;
    logic       btn_clr = 1'b0;
    logic [3:0] cnt_val = 4'd0;
    logic       cnt_en;
    logic       cnt_up;
    logic       cnt_clr;
    logic [1:0] state;

    int   n_checks = 0;
    int   n_fail = 0;
    logic sb_on = 1'b1;
    sb_t  sb_q[$];
    sb_t  mon_e;
    vec_t vecs[NV];

    led_count_ctrl #(.W(4), .TICK_DIV(4), .DB_CYCLES(3)) dut (
        .clk(clk), .rst_btn_n(rst_btn_n), .sw_dir(sw_dir), .sw_bounce(sw_bounce),
        .btn_pause(btn_pause), .btn_step(btn_step), .btn_clr(btn_clr),
        .cnt_val(cnt_val), .cnt_en(cnt_en), .cnt_up(cnt_up), .cnt_clr(cnt_clr),
        .state(state)
    );

    always #5 clk = ~clk;

    // Datapath stand-in: wraps freely in both directions
    always @(posedge clk) begin
        if (cnt_clr) cnt_val <= 4'd0;
        else if (cnt_en) cnt_val <= cnt_up ? cnt_val + 4'd1 : cnt_val - 4'd1;
    end

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push_run(input logic up, input int from, input int n, input int stp);
        for (int k = 0; k < n; k++)
            sb_q.push_back({up, 4'(((from + k * stp) % 16 + 16) % 16)});
    endtask

    task automatic wait_empty(input int budget, input string name);
        for (int k = 0; k < budget && sb_q.size() != 0; k++) begin
            @(posedge clk); #1;
        end
        chk(name, sb_q.size(), 0);
    endtask

    // Scoreboard monitor, sampled on the falling edge
    always @(negedge clk) begin
        if (cnt_clr) chk("clr_excludes_en", int'(cnt_en), 0);
        if (sb_on && cnt_en) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_strobe", 1, 0);
            end else begin
                mon_e = sb_q.pop_front();
                chk("sb_cnt_up", int'(cnt_up), int'(mon_e.up));
                chk("sb_cnt_val", int'(cnt_val), int'(mon_e.val));
            end
        end
    end

    initial begin
        int n_en, n_step, n_clr, k;

        //          pause  step   clr   win st strb stp clr val
        vecs[0] = '{1'b1, 1'b0, 1'b0, 24, 2, -1, 0, 0, -1};  // RUN -> PAUSE
        vecs[1] = '{1'b0, 1'b0, 1'b0, 50, 2,  0, 0, 0, -1};  // idle in PAUSE
        vecs[2] = '{1'b0, 1'b1, 1'b0, 24, 2,  1, 1, 0, -1};  // step
        vecs[3] = '{1'b0, 1'b1, 1'b0, 24, 2,  1, 1, 0, -1};  // step
        vecs[4] = '{1'b0, 1'b1, 1'b0, 24, 2,  1, 1, 0, -1};  // step
        vecs[5] = '{1'b1, 1'b0, 1'b0, 24, 1, -1, 0, 0, -1};  // PAUSE -> RUN
        vecs[6] = '{1'b0, 1'b1, 1'b0, 40, 1, 10, 0, 0, -1};  // step in RUN dropped
        vecs[7] = '{1'b1, 1'b0, 1'b0, 24, 2, -1, 0, 0, -1};  // RUN -> PAUSE
        vecs[8] = '{1'b1, 1'b0, 1'b1, 24, 2,  0, 0, 1,  0};  // clr beats pause
        vecs[9] = '{1'b1, 1'b0, 1'b0, 24, 1, -1, 0, 0, -1};  // PAUSE -> RUN

        #2 rst_btn_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_cnt_en", int'(cnt_en), 0);
        chk("rst_cnt_clr", int'(cnt_clr), 0);
        chk("rst_cnt_up", int'(cnt_up), 1);
        chk("rst_state", int'(state), 0);

        // Reset and run: 0..15 then wrap to 0,1, all counting up
        push_run(1'b1, 0, 18, 1);
        rst_btn_n = 1'b1;
        @(posedge clk); #1;
        chk("cyc1_cnt_clr", int'(cnt_clr), 1);
        chk("cyc1_state", int'(state), 0);
        @(posedge clk); #1;
        chk("cyc2_state", int'(state), 1);
        chk("cyc2_cnt_clr", int'(cnt_clr), 0);
        wait_empty(200, "run_sequence_done");

        // Manual reverse at 5: one more up event lands before the debounce settles
        push_run(1'b1, 2, 4, 1);
        push_run(1'b0, 6, 9, -1);
        for (k = 0; k < 100 && cnt_val != 4'd5; k++) begin
            @(posedge clk); #1;
        end
        chk("reach_val5", int'(cnt_val), 5);
        sw_dir = 1'b0;
        wait_empty(200, "reverse_sequence_done");

        // Bounce: sw_dir flipped back up must be ignored, turn at 0 and at 15
        sw_bounce = 1'b1;
        sw_dir = 1'b1;
        push_run(1'b0, 13, 13, -1);
        push_run(1'b1, 0, 15, 1);
        push_run(1'b0, 15, 3, -1);
        wait_empty(300, "bounce_sequence_done");
        sb_on = 1'b0;

        for (int i = 0; i < NV; i++) begin
            n_en = 0;
            n_step = 0;
            n_clr = 0;
            for (int c = 0; c < vecs[i].win; c++) begin
                btn_pause = (c < 6) ? vecs[i].pause : 1'b0;
                btn_step  = (c < 6) ? vecs[i].step  : 1'b0;
                btn_clr   = (c < 6) ? vecs[i].clr   : 1'b0;
                @(posedge clk); #1;
                if (cnt_en) n_en++;
                if (cnt_clr) n_clr++;
                if (state == 2'd3) n_step++;
            end
            chk($sformatf("vec%0d_state", i), int'(state), vecs[i].exp_state);
            if (vecs[i].exp_strobes >= 0)
                chk($sformatf("vec%0d_strobes", i), n_en, vecs[i].exp_strobes);
            chk($sformatf("vec%0d_step_cycles", i), n_step, vecs[i].exp_step);
            chk($sformatf("vec%0d_clr_pulses", i), n_clr, vecs[i].exp_clrs);
            if (vecs[i].exp_val >= 0)
                chk($sformatf("vec%0d_cnt_val", i), int'(cnt_val), vecs[i].exp_val);
        end

        // Reset mid-RUN, asserted between clock edges
        repeat (7) @(posedge clk);
        #3 rst_btn_n = 1'b0;
        #1;
        chk("midrst_cnt_en", int'(cnt_en), 0);
        chk("midrst_cnt_clr", int'(cnt_clr), 0);
        chk("midrst_cnt_up", int'(cnt_up), 1);
        chk("midrst_state", int'(state), 0);
        repeat (2) @(posedge clk);
        #1 rst_btn_n = 1'b1;
        for (int c = 1; c <= 6; c++) begin
            @(posedge clk); #1;
            chk($sformatf("rel_c%0d_cnt_clr", c), int'(cnt_clr), (c == 1) ? 1 : 0);
            chk($sformatf("rel_c%0d_cnt_en", c), int'(cnt_en), (c == 6) ? 1 : 0);
            chk($sformatf("rel_c%0d_state", c), int'(state), (c == 1) ? 0 : 1);
            if (c == 2) chk("rel_cnt_val_cleared", int'(cnt_val), 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
